fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Parametrised instruction-fetch front end between the instruction memory (`program_counter` ROM, combinational read) and the `instruction_decode_controller`. Generates fetch addresses, prefetches sequential instructions into a small flushable queue, and hands them to decode with a valid/ready handshake. Redirects (branch/jump targets from decode) flush the queue and restart fetch. PREFETCH=0 gives legacy one-instruction-per-redirect fetch.

## Interface
- `PC_WIDTH`, `$clog2(`NUMBER_OF_PC_REGISTERS)`, fetch address width
- `INSTR_WIDTH`, OPERATION_TYPE_WIDTH+OPCODE_WIDTH+3*ADDR_WIDTH+PC_WIDTH+WORD_SIZE, instruction word width
- `PC_LIMIT`, `NUMBER_OF_PC_REGISTERS`, addresses 0..PC_LIMIT-1 valid; sequential wrap point
- `QUEUE_DEPTH`, 4, queue entries; power of two, >=2
- `PREFETCH`, 1, 1 = sequential prefetch; 0 = fetch one, wait for redirect
- `RESET_PC`, 0, first fetch address
- `clk` in 1, single clock
- `rst` in 1, reset; synchronous, active-high
- `fetch_en` in 1, 0 freezes fetch (issue side still drains)
- `imem_addr` out PC_WIDTH, ROM address (= fetch_pc)
- `imem_rdata` in INSTR_WIDTH, ROM data, valid same cycle
- `redirect_valid` in 1, one-cycle redirect strobe from decode
- `redirect_pc` in PC_WIDTH, redirect target
- `issue_valid` out 1, queue head valid
- `issue_ready` in 1, decode accepts head
- `issue_instr` out INSTR_WIDTH, head instruction
- `issue_pc` out PC_WIDTH, head instruction address
- `queue_count` out $clog2(QUEUE_DEPTH+1), occupied entries

## Operation
- States: FETCH, WAIT_REDIRECT (reachable only when PREFETCH=0).
- Write condition (FETCH): `fetch_en` & (!full | pop) & !redirect_valid. Writes {imem_rdata, fetch_pc}; fetch_pc <= fetch_pc+1, or 0 when fetch_pc == PC_LIMIT-1.
- Pop: issue_valid & issue_ready. Head advances next cycle.
- PREFETCH=0: after a write, FETCH -> WAIT_REDIRECT; held until redirect_valid.
- Redirect (highest priority, any state): queue flushed (count 0), fetch_pc <= redirect_pc, state <= FETCH. Same-cycle write discarded; same-cycle pop counts as consumed (decode owns that instruction).
- Full & pop & write: both occur, count unchanged. Empty: issue_valid=0, issue_instr/issue_pc hold last head value (don't care).
- redirect_pc >= PC_LIMIT: fetched as given; no check.

## Timing
- Reset (cycle after rst sampled high): fetch_pc=RESET_PC, state FETCH, queue empty, issue_valid=0, queue_count=0, imem_addr=RESET_PC. rst mid-operation: same, pending entries discarded.
- Fetch-to-issue latency 1: write at edge N, issue_valid=1 in cycle N+1.
- Redirect sampled at edge N: imem_addr=redirect_pc during N+1, issue_valid=1 with issue_pc=redirect_pc during N+2 (if fetch_en).
- Sustained throughput 1 instr/cycle with PREFETCH=1 and issue_ready held high.
- issue_instr/issue_pc stable while issue_valid & !issue_ready (except redirect).

## Structure
- `defines.vh`: NUMBER_OF_PC_REGISTERS, OPERATION_TYPE_WIDTH, OPCODE_WIDTH, NUMBER_OF_REGISTERS, WORD_SIZE; add FETCH_QUEUE_DEPTH default and state encodings.
- Sub-module `fetch_queue`: synchronous FIFO, width INSTR_WIDTH+PC_WIDTH, depth QUEUE_DEPTH, push/pop/flush, full/empty/count; flush dominates push.
- `fetch_sequencer`: fetch_pc register, state FSM, write/redirect logic.

## Test plan
- Reset, PREFETCH=1, issue_ready=1, ROM[i]=i: issue_pc sequence 0,1,2,3... from cycle 1, one per cycle; wrap PC_LIMIT-1 -> 0.
- issue_ready=0 for 10 cycles: queue_count reaches 4, imem_addr holds 4, head stays pc 0; release -> pcs 0..4 in order, no loss/duplicate.
- Redirect to 9 at cycle with count=3 and pop: count 0 next cycle, imem_addr=9, issue_pc=9 two cycles after strobe; popped entry not reissued.
- PREFETCH=0: one entry (pc 0) then WAIT_REDIRECT, imem_addr static; redirect to 5 -> exactly one entry pc 5.
- fetch_en=0 with count=2: two entries drain, issue_valid falls, no new writes; fetch_en=1 resumes at held fetch_pc.
- rst asserted with count=3: next cycle count 0, issue_valid 0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, widths and FSM encoding for the instruction-fetch front end.
package fetch_sequencer_pkg;

  // Machine-level sizing shared with the decode and register-file blocks.
  localparam int NUMBER_OF_PC_REGISTERS = 16;
  localparam int OPERATION_TYPE_WIDTH   = 2;
  localparam int OPCODE_WIDTH           = 4;
  localparam int NUMBER_OF_REGISTERS    = 8;
  localparam int WORD_SIZE              = 8;
  localparam int ADDR_WIDTH             = $clog2(NUMBER_OF_REGISTERS);

  // Default prefetch queue depth (power of two, at least 2).
  localparam int FETCH_QUEUE_DEPTH      = 4;

  // Fetch FSM: WAIT_REDIRECT is only entered in single-fetch (PREFETCH=0) mode.
  typedef enum logic [0:0] {
    ST_FETCH         = 1'b0,
    ST_WAIT_REDIRECT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Flushable synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush dominates push; a pop on an empty queue is ignored.
module fetch_sequencer_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ~flush & (~full | pop_ok);

  // Entry storage: data only, never reset (occupancy is tracked by count_q).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives the ROM address, prefetches sequential
// instructions into a small queue and hands them to decode via valid/ready.
// A redirect from decode flushes the queue and restarts fetch at the target.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = $clog2(NUMBER_OF_PC_REGISTERS),
  parameter int INSTR_WIDTH = OPERATION_TYPE_WIDTH + OPCODE_WIDTH + 3*ADDR_WIDTH
                              + PC_WIDTH + WORD_SIZE,
  parameter int PC_LIMIT    = NUMBER_OF_PC_REGISTERS,
  parameter int QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PREFETCH    = 1,
  parameter int RESET_PC    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_en,
  output logic [PC_WIDTH-1:0]              imem_addr,
  input  logic [INSTR_WIDTH-1:0]           imem_rdata,
  input  logic                             redirect_valid,
  input  logic [PC_WIDTH-1:0]              redirect_pc,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [INSTR_WIDTH-1:0]           issue_instr,
  output logic [PC_WIDTH-1:0]              issue_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

  localparam int                CNT_W    = $clog2(QUEUE_DEPTH+1);
  localparam int                ENTRY_W  = INSTR_WIDTH + PC_WIDTH;
  localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(PC_LIMIT - 1);
  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] fetch_pc_inc;
  logic                fetch_write;
  logic                issue_pop;
  logic                q_full;
  logic                q_empty;
  logic [ENTRY_W-1:0]  q_rd_data;
  logic [CNT_W-1:0]    q_count;

  assign imem_addr    = fetch_pc_q;
  assign issue_valid  = ~q_empty;
  assign queue_count  = q_count;
  assign {issue_instr, issue_pc} = q_rd_data;

  // Sequential successor of the fetch address, wrapping at the program end.
  assign fetch_pc_inc = (fetch_pc_q == LAST_PC) ? '0 : fetch_pc_q + PC_WIDTH'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: redirect always restarts fetch; single-fetch mode parks after one write.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_FETCH;
    end else if ((PREFETCH == 0) && fetch_write) begin
      state_d = ST_WAIT_REDIRECT;
    end
  end

  // FSM outputs: queue write and issue pop; a redirect discards the same-cycle fetch.
  always_comb begin
    issue_pop   = ~q_empty & issue_ready;
    fetch_write = 1'b0;
    if (state_q == ST_FETCH) begin
      fetch_write = fetch_en & (~q_full | issue_pop) & ~redirect_valid;
    end
  end

  // Fetch address: reset value, redirect target, or advance after each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= START_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
    end else if (fetch_write) begin
      fetch_pc_q <= fetch_pc_inc;
    end
  end

  fetch_sequencer_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (fetch_write),
    .pop     (issue_pop),
    .flush   (redirect_valid),
    .wr_data ({imem_rdata, fetch_pc_q}),
    .rd_data (q_rd_data),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a single-fetch (PREFETCH=0) and a prefetching
// (PREFETCH=1) instance share stimulus; each is compared every cycle against
// a list-based reference model of the fetch/issue rules.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PCW   = $clog2(NUMBER_OF_PC_REGISTERS);
  localparam int IW    = OPERATION_TYPE_WIDTH + OPCODE_WIDTH + 3*ADDR_WIDTH + PCW + WORD_SIZE;
  localparam int LIMIT = 12;
  localparam int QD    = 4;
  localparam int CW    = $clog2(QD+1);

  logic           clk = 1'b0;
  logic           rst;
  logic           fetch_en;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           issue_ready;

  logic [PCW-1:0] imem_addr   [2];
  logic [IW-1:0]  imem_rdata  [2];
  logic           issue_valid [2];
  logic [IW-1:0]  issue_instr [2];
  logic [PCW-1:0] issue_pc    [2];
  logic [CW-1:0]  queue_count [2];

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: ordered list of queued pcs.
  int m_cnt  [2];
  int m_fpc  [2];
  bit m_wait [2];
  int m_q    [2][QD];

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom_word(input logic [PCW-1:0] a);
    logic [31:0] v;
    v = (32'(a) + 32'd1) * 32'h0123_4567 ^ 32'h05A5_A5A5;
    return v[IW-1:0];
  endfunction

  assign imem_rdata[0] = rom_word(imem_addr[0]);
  assign imem_rdata[1] = rom_word(imem_addr[1]);

  fetch_sequencer #(
    .PC_LIMIT(LIMIT), .QUEUE_DEPTH(QD), .PREFETCH(0), .RESET_PC(0)
  ) dut0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue_valid(issue_valid[0]), .issue_ready(issue_ready),
    .issue_instr(issue_instr[0]), .issue_pc(issue_pc[0]),
    .queue_count(queue_count[0])
  );

  fetch_sequencer #(
    .PC_LIMIT(LIMIT), .QUEUE_DEPTH(QD), .PREFETCH(1), .RESET_PC(0)
  ) dut1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .issue_valid(issue_valid[1]), .issue_ready(issue_ready),
    .issue_instr(issue_instr[1]), .issue_pc(issue_pc[1]),
    .queue_count(queue_count[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one clock edge of the fetch/issue rules to instance d.
  task automatic model_step(input int d, input int prefetch);
    bit pop;
    bit wr;
    pop = (m_cnt[d] > 0) && issue_ready;
    if (rst) begin
      m_cnt[d] = 0; m_fpc[d] = 0; m_wait[d] = 1'b0;
    end else if (redirect_valid) begin
      m_cnt[d] = 0; m_fpc[d] = int'(redirect_pc); m_wait[d] = 1'b0;
    end else begin
      wr = !m_wait[d] && fetch_en && ((m_cnt[d] < QD) || pop);
      if (pop) begin
        for (int i = 0; i < QD-1; i++) m_q[d][i] = m_q[d][i+1];
        m_cnt[d]--;
      end
      if (wr) begin
        m_q[d][m_cnt[d]] = m_fpc[d];
        m_cnt[d]++;
        m_fpc[d] = (m_fpc[d] == LIMIT-1) ? 0 : (m_fpc[d] + 1) % 16;
        if (prefetch == 0) m_wait[d] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_issue_valid", d), 32'(issue_valid[d]), 32'(m_cnt[d] > 0));
      chk($sformatf("d%0d_queue_count", d), 32'(queue_count[d]), 32'(m_cnt[d]));
      chk($sformatf("d%0d_imem_addr", d),   32'(imem_addr[d]),   32'(m_fpc[d]));
      if (m_cnt[d] > 0) begin
        chk($sformatf("d%0d_issue_pc", d),    32'(issue_pc[d]),    32'(m_q[d][0]));
        chk($sformatf("d%0d_issue_instr", d), 32'(issue_instr[d]),
            32'(rom_word(PCW'(m_q[d][0]))));
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(0, 0);
      model_step(1, 1);
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_fpc[d] = 0; m_wait[d] = 1'b0;
      for (int i = 0; i < QD; i++) m_q[d][i] = 0;
    end
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; issue_ready = 1'b1;
    step(2);

    // Streaming with ready held high, long enough to wrap LIMIT-1 -> 0.
    rst = 1'b0;
    step(20);

    // Decode back-pressure: queue fills and fetch address holds.
    issue_ready = 1'b0;
    step(10);
    issue_ready = 1'b1;
    step(3);

    // Redirect while the head is being popped.
    redirect_valid = 1'b1; redirect_pc = PCW'(9);
    step(1);
    redirect_valid = 1'b0;
    step(4);

    // Fetch frozen: queue drains, nothing new written, then resume.
    fetch_en = 1'b0;
    step(6);
    fetch_en = 1'b1;
    step(4);

    // Redirect beyond the program limit is fetched as given.
    redirect_valid = 1'b1; redirect_pc = PCW'(14);
    step(1);
    redirect_valid = 1'b0;
    step(6);

    // Reset in the middle of operation with entries pending.
    issue_ready = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0; issue_ready = 1'b1;
    step(3);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      issue_ready    = ($urandom_range(0, 3) != 0);
      fetch_en       = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = PCW'($urandom_range(0, 15));
      rst            = ($urandom_range(0, 99) == 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
